// File: rtl/decode_issue_queue.sv
// decode_issue_queue: circular fetch buffer with head decode and registered dual-issue output stage
module decode_issue_queue #(
  parameter int DEPTH   = 8,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic [FETCH_W-1:0]    in_valid,
  input  logic [32*FETCH_W-1:0] in_instr,
  input  logic [32*FETCH_W-1:0] in_pc,
  output logic                  in_ready,
  output logic [ISSUE_W-1:0]    out_valid,
  output logic [32*ISSUE_W-1:0] out_instr,
  output logic [32*ISSUE_W-1:0] out_pc,
  output logic [13*ISSUE_W-1:0] out_ctrl,
  input  logic                  out_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // ctrl layout: {regwrite, regdst[1:0], is_imm, memtoreg, mem_read, mem_write, hilo_wen, ri, branch_judge[2:0], sign_ex}
  function automatic logic [12:0] decode(input logic [31:0] i);
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rw, ii, mr, mw, hw, ri;
    logic [1:0] rd;
    logic [2:0] bj;
    op = i[31:26];
    fn = i[5:0];
    rs = i[25:21];
    rt = i[20:16];
    rw = 1'b0; ii = 1'b0; mr = 1'b0; mw = 1'b0; hw = 1'b0; ri = 1'b0;
    rd = 2'b00;
    bj = 3'b000;
    case (op)
      6'h00: case (fn)
        6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12,
        6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
        6'h2a, 6'h2b: rw = 1'b1;
        6'h09: begin rw = 1'b1; rd = 2'b10; end
        6'h11, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b: hw = 1'b1;
        6'h08, 6'h0c, 6'h0d: ;
        default: ri = 1'b1;
      endcase
      6'h01: case (rt)
        5'h00: bj = 3'b101;
        5'h01: bj = 3'b110;
        5'h10: begin bj = 3'b101; rw = 1'b1; rd = 2'b10; end
        5'h11: begin bj = 3'b110; rw = 1'b1; rd = 2'b10; end
        default: ri = 1'b1;
      endcase
      6'h02: ;
      6'h03: begin rw = 1'b1; rd = 2'b10; end
      6'h04: bj = 3'b001;
      6'h05: bj = 3'b010;
      6'h06: bj = 3'b011;
      6'h07: bj = 3'b100;
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin rw = 1'b1; rd = 2'b01; ii = 1'b1; end
      6'h10: begin
        if (rs == 5'h00) begin rw = 1'b1; rd = 2'b01; end
        else if (rs != 5'h04 && i[25:0] != 26'h2000018) ri = 1'b1;
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin rw = 1'b1; rd = 2'b01; ii = 1'b1; mr = 1'b1; end
      6'h28, 6'h29, 6'h2b: begin ii = 1'b1; mw = 1'b1; end
      default: ri = 1'b1;
    endcase
    return {rw, rd, ii, mr, mr, mw, hw, ri, bj, op[5:2] != 4'b0011};
  endfunction

  // instructions that touch HI/LO or CP0 state and must issue alone
  function automatic logic serial(input logic [31:0] i);
    return (i[31:26] == 6'h00 && (i[5:0] == 6'h10 || i[5:0] == 6'h12)) ||
           (i[31:26] == 6'h10 && (i[25:21] == 5'h00 || i[25:21] == 5'h04));
  endfunction

  // instructions that redirect to an exception path; nothing may issue beside them
  function automatic logic trap(input logic [31:0] i);
    return (i[31:26] == 6'h00 && (i[5:0] == 6'h0c || i[5:0] == 6'h0d)) || i == 32'h42000018;
  endfunction

  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count, n_in, n_wr, n_iss;
  logic [1:0]    v_r;
  logic [31:0]   i_r [2];
  logic [31:0]   p_r [2];
  logic [12:0]   c_r [2];
  logic [31:0]   h0, h1;
  logic [12:0]   c0, c1;
  logic [4:0]    d0;
  logic          load, take0, take1, raw;

  assign in_ready = resetn && (count <= CW'(DEPTH - FETCH_W));
  assign h0       = q_instr[head];
  assign h1       = q_instr[head + AW'(1)];
  assign c0       = decode(h0);
  assign c1       = decode(h1);
  assign d0       = c0[11:10] == 2'b00 ? h0[15:11] : c0[11:10] == 2'b01 ? h0[20:16] : 5'd31;
  assign raw      = c0[12] && d0 != 5'd0 && (d0 == h1[25:21] || d0 == h1[20:16]);
  assign load     = v_r == 2'b00 || out_ready;
  assign take0    = count != '0;
  assign take1    = ISSUE_W == 2 && count >= CW'(2) && !raw &&
                    !((c0[7] | c0[6]) && (c1[7] | c1[6])) &&
                    !(c0[5] | c1[5] | serial(h0) | serial(h1)) &&
                    !(trap(h0) | c0[4]);
  assign n_wr     = in_ready ? n_in : '0;
  assign n_iss    = load ? CW'(take0) + CW'(take1) : '0;

  // number of valid fetch slots offered this cycle
  always_comb begin
    n_in = '0;
    for (int k = 0; k < FETCH_W; k++) n_in = n_in + CW'(in_valid[k]);
  end

  // queue storage: slot k lands at tail+k, no reset needed since pointers gate visibility
  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_W; k++)
      if (in_ready && !flush && in_valid[k]) begin
        q_instr[tail + AW'(k)] <= in_instr[32*k +: 32];
        q_pc[tail + AW'(k)]    <= in_pc[32*k +: 32];
      end
  end

  // head/tail/count bookkeeping; flush shares the reset path
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(n_iss);
      tail  <= tail + AW'(n_wr);
      count <= count + n_wr - n_iss;
    end
  end

  // registered issue stage: reload when empty or consumed, otherwise hold
  always_ff @(posedge clk) begin
    if (!resetn) begin
      v_r <= '0;
      for (int s = 0; s < 2; s++) begin
        i_r[s] <= '0;
        p_r[s] <= '0;
        c_r[s] <= '0;
      end
    end else if (flush) begin
      v_r <= '0;
    end else if (load) begin
      v_r    <= {take1, take0};
      i_r[0] <= h0;
      i_r[1] <= h1;
      p_r[0] <= q_pc[head];
      p_r[1] <= q_pc[head + AW'(1)];
      c_r[0] <= c0;
      c_r[1] <= c1;
    end
  end

  // flatten the issue stage onto the output buses
  always_comb begin
    for (int s = 0; s < ISSUE_W; s++) begin
      out_valid[s]          = v_r[s];
      out_instr[32*s +: 32] = i_r[s];
      out_pc[32*s +: 32]    = p_r[s];
      out_ctrl[13*s +: 13]  = c_r[s];
    end
  end
endmodule

// File: tb/tb_decode_issue_queue.sv
// tb_decode_issue_queue: directed stimulus with a scoreboard-fed issue monitor
module tb_decode_issue_queue;
  logic        clk = 1'b0;
  logic        resetn, flush, out_ready, in_ready;
  logic [1:0]  in_valid, out_valid;
  logic [63:0] in_instr, in_pc, out_instr, out_pc;
  logic [25:0] out_ctrl;
  int          compares = 0;
  int          fails = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [12:0] ctrl;
    logic [1:0]  slot;
  } exp_t;

  exp_t sb[$];

  decode_issue_queue dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_ctrl(out_ctrl),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    compares++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_issue(input logic [31:0] i, input logic [31:0] p, input logic [12:0] c, input logic [1:0] s);
    sb.push_back('{i, p, c, s});
  endtask

  function automatic logic [31:0] addu(input int rd);
    return 32'h21 | (32'(rd) << 11);
  endfunction

  task automatic send(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] p0,
                      input logic [31:0] i1, input logic [31:0] p1);
    int n;
    in_valid = v;
    in_instr = {i1, i0};
    in_pc    = {p1, p0};
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
    step();
    in_valid = 2'b00;
  endtask

  // monitor: every slot taken by the consumer is matched against the next expected issue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && !flush && out_ready)
        for (int s = 0; s < 2; s++)
          if (out_valid[s]) begin
            if (sb.size() == 0) begin
              chk("unexpected_issue", 64'(out_instr[32*s +: 32]), 64'hx);
            end else begin
              e = sb.pop_front();
              chk("issue_instr", 64'(out_instr[32*s +: 32]), 64'(e.instr));
              chk("issue_pc", 64'(out_pc[32*s +: 32]), 64'(e.pc));
              chk("issue_ctrl", 64'(out_ctrl[13*s +: 13]), 64'(e.ctrl));
              chk("issue_slot", 64'(s), 64'(e.slot));
            end
          end
    end
  end

  initial begin
    resetn = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = '0; in_instr = '0; in_pc = '0;
    step();
    step();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_instr", out_instr, 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    resetn = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    // RAW on $2 splits ADDIU/ADDU
    expect_issue(32'h24020005, 32'h100, 13'h1601, 2'd0);
    expect_issue(32'h00431021, 32'h104, 13'h1001, 2'd0);
    send(2'b11, 32'h24020005, 32'h100, 32'h00431021, 32'h104);
    chk("no_bypass", 64'(out_valid), 64'd0);
    step();
    chk("lat_valid", 64'(out_valid), 64'b01);
    chk("lat_ctrl0", 64'(out_ctrl[12:0]), 64'h1601);
    step();
    chk("raw_split_valid", 64'(out_valid), 64'b01);
    chk("raw_split_instr", 64'(out_instr[31:0]), 64'h00431021);
    repeat (3) step();
    // two memory ops never pair
    expect_issue(32'h8C430000, 32'h200, 13'h1781, 2'd0);
    expect_issue(32'hAC640004, 32'h204, 13'h0241, 2'd0);
    send(2'b11, 32'h8C430000, 32'h200, 32'hAC640004, 32'h204);
    repeat (4) step();
    // fill with the consumer stalled, then drain two per cycle across the wrap
    out_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      expect_issue(addu(2*j+1), 32'h300 + 32'(8*j), 13'h1001, 2'd0);
      expect_issue(addu(2*j+2), 32'h304 + 32'(8*j), 13'h1001, 2'd1);
      send(2'b11, addu(2*j+1), 32'h300 + 32'(8*j), addu(2*j+2), 32'h304 + 32'(8*j));
    end
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_out_valid", 64'(out_valid), 64'b11);
    step();
    chk("stall_hold", out_instr, {addu(2), addu(1)});
    out_ready = 1'b1;
    repeat (8) step();
    chk("drained_in_ready", 64'(in_ready), 64'd1);
    chk("drained_out_valid", 64'(out_valid), 64'd0);
    // illegal opcode issues alone with ri set
    expect_issue(32'hFC000000, 32'h400, 13'h0011, 2'd0);
    expect_issue(addu(7), 32'h404, 13'h1001, 2'd0);
    send(2'b11, 32'hFC000000, 32'h400, addu(7), 32'h404);
    repeat (4) step();
    // JAL+LW and BEQ+ORI are independent pairs
    expect_issue(32'h0C000010, 32'h410, 13'h1801, 2'd0);
    expect_issue(32'h8C430000, 32'h414, 13'h1781, 2'd1);
    send(2'b11, 32'h0C000010, 32'h410, 32'h8C430000, 32'h414);
    repeat (3) step();
    expect_issue(32'h10220003, 32'h420, 13'h0003, 2'd0);
    expect_issue(32'h34A50001, 32'h424, 13'h1600, 2'd1);
    send(2'b11, 32'h10220003, 32'h420, 32'h34A50001, 32'h424);
    repeat (3) step();
    // flush with count=5 and a full output stage
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) send(2'b11, addu(20), 32'h900, addu(21), 32'h904);
    send(2'b01, addu(22), 32'h908, addu(23), 32'h90C);
    chk("pre_flush_valid", 64'(out_valid), 64'b11);
    flush = 1'b1;
    in_valid = 2'b11;
    in_instr = {addu(25), addu(24)};
    step();
    flush = 1'b0;
    in_valid = 2'b00;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    expect_issue(addu(9), 32'h500, 13'h1001, 2'd0);
    send(2'b01, addu(9), 32'h500, 32'h0, 32'h0);
    repeat (4) step();
    // reset mid-stream with both slots valid
    out_ready = 1'b0;
    send(2'b11, addu(26), 32'hA00, addu(27), 32'hA04);
    send(2'b11, addu(28), 32'hA08, addu(29), 32'hA0C);
    chk("pre_rst_valid", 64'(out_valid), 64'b11);
    resetn = 1'b0;
    step();
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_instr", out_instr, 64'd0);
    chk("mid_rst_pc", out_pc, 64'd0);
    chk("mid_rst_ctrl", 64'(out_ctrl), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    resetn = 1'b1;
    #1;
    chk("after_rst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    expect_issue(addu(11), 32'h600, 13'h1001, 2'd0);
    send(2'b01, addu(11), 32'h600, 32'h0, 32'h0);
    repeat (4) step();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end
endmodule

// File: doc/decode_issue_queue.md
Name: decode_issue_queue

Overview:
Parametrised successor to the single-instruction main decoder. Buffers up to FETCH_W fetched MIPS32 instructions per cycle in a circular queue, decodes the head entries, and issues up to ISSUE_W instructions per cycle through a registered output stage with valid/ready handshake. Includes in-order pair-issue hazard checks and flush. Sits between the fetch stage and the ID/EX pipeline register.

Parameters:
DEPTH, 8, queue entries; power of 2, >= 2*FETCH_W
FETCH_W, 2, instructions accepted per cycle (1 or 2)
ISSUE_W, 2, instructions issued per cycle (1 or 2)

Ports:
clk  in  1  clock, rising edge
resetn  in  1  synchronous active-low reset
flush  in  1  discard queue and output stage
in_valid  in  FETCH_W  per-slot valid; slot k valid requires slots <k valid
in_instr  in  32*FETCH_W  instructions, slot 0 oldest, in [31:0]
in_pc  in  32*FETCH_W  PCs of in_instr
in_ready  out  1  free entries >= FETCH_W
out_valid  out  ISSUE_W  issued slot valid; slot 1 only with slot 0
out_instr  out  32*ISSUE_W  issued instructions
out_pc  out  32*ISSUE_W  issued PCs
out_ctrl  out  13*ISSUE_W  per slot {regwrite, regdst[1:0], is_imm, memtoreg, mem_read, mem_write, hilo_wen, ri, branch_judge[2:0], sign_ex}
out_ready  in  1  consumer takes all valid out slots this cycle

Behaviour:
- Reset: clk and resetn are the only clock and reset; reset is synchronous and active-low. On a rising edge with resetn=0: head, tail and count = 0; out_valid = 0; out_instr, out_pc, out_ctrl = 0; in_ready = 0 during reset and 1 on the first cycle after.
- Write: on an edge with in_ready=1, each slot k with in_valid[k]=1 is written at tail+k mod DEPTH. Tail advances by the number of valid slots. The pointer wraps modulo DEPTH.
- Output stage load condition: load = (out_valid==0) | out_ready. When load=1, the stage takes up to ISSUE_W head entries, and head advances by the number taken. When load=0, the stage holds its contents exactly.
- Latency: an instruction written at edge N is visible on out_valid after edge N+1 at the earliest. There is no bypass from input to output.
- Count update: count += written - issued. Write and issue in the same edge are both legal. A full queue with a simultaneous issue still deasserts in_ready, because in_ready is computed from the registered count.
- Pair rule, slot 1 loads only if all of the following hold:
  - count >= 2 and ISSUE_W = 2;
  - NOT (slot0 regwrite and dest0 != 0 and dest0 is equal to rs1 or rt1). dest0 is rd, rt, or 31 for regdst 00, 01, 10.
  - NOT (both slots are memory ops);
  - NOT (either slot has hilo_wen, or either slot is MFHI/MFLO, MTC0 or MFC0);
  - NOT (slot0 is SYSCALL, BREAK, ERET, or has ri=1).
  If slot 1 is held, it stays at the head for the next load.
- Decode (combinational on queue head):
  - R-type ALU ops, MFHI/MFLO: regwrite=1, regdst=00.
  - JALR, JAL, BGEZAL, BLTZAL: regwrite=1, regdst=10.
  - I-type ALU ops and loads: regwrite=1, regdst=01, is_imm=1. Loads also set memtoreg=1, mem_read=1.
  - Stores: is_imm=1, mem_write=1.
  - MFC0: regwrite=1, regdst=01.
  - MULT, MULTU, DIV, DIVU, MTHI, MTLO: hilo_wen=1.
  - branch_judge: BEQ 001, BNE 010, BLEZ 011, BGTZ 100, BLTZ/BLTZAL 101, BGEZ/BGEZAL 110, else 000.
  - sign_ex = 0 only for opcodes 0011xx, else 1.
  - ri=1 for an unknown opcode, unknown R-type funct, unknown REGIMM rt, or COP0 that is not MTC0/MFC0/ERET. ERET requires instr[25:0] = 0x2000018. Any ri=1 instruction has all enables 0.
- Flush (has priority over everything, including a same-cycle write or load): head = tail = count = 0 and out_valid = 0 on that edge. in_valid in the flush cycle is ignored.
- in_valid while in_ready=0 is ignored; the producer holds it.

Test Plan:
- Reset then push 0x24020005 (ADDIU $2,$0,5) and 0x00431021 (ADDU $2,$2,$3) at edge 1 -> out_valid=01 after edge 2 with ctrl0 regwrite=1, regdst=01, is_imm=1; after edge 3 (out_ready=1) out_valid=01 with ADDU, because the RAW on $2 splits the pair.
- Push 0x8C430000 (LW) and 0xAC640004 (SW) -> issued singly on consecutive loads; LW ctrl mem_read=1, memtoreg=1; SW mem_write=1, regwrite=0.
- Fill 8 entries with out_ready=0 -> in_ready=0 after count reaches 7 (FETCH_W=2); 6 further cycles of out_ready=1 with independent ADDUs drain 2 per cycle; head and tail wrap to 0 correctly.
- Push 0xFC000000 (illegal opcode) -> ri=1, regwrite=0, slot 1 not paired.
- Assert flush with count=5, out_valid=11, in_valid=11 -> next cycle out_valid=00, count=0, in_ready=1.
- Drive resetn=0 for one edge mid-stream with out_valid=11 -> out_valid=00 and all outputs 0 after that edge.
